// File: rtl/uart_frame_chk.sv
// UART RX frame checker: start/data/parity/stop validation with registered result pulses.
// Optional saturating error counters are built when UART_FRAME_ERR_CNT_EN is defined.
module uart_frame_chk #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              bit_vld,
    input  logic              sampled_bit,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              two_stop,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              strt_glitch,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
`ifdef UART_FRAME_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt_strt,
    output logic [ERR_CNT_W-1:0] err_cnt_par,
    output logic [ERR_CNT_W-1:0] err_cnt_stp
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Elaboration-time guard on the supported parameter range.
    if (DATA_W < 5 || DATA_W > 9 || ERR_CNT_W < 1) begin : g_bad_param
        $error("uart_frame_chk: DATA_W must be 5..9 and ERR_CNT_W >= 1");
    end

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [DATA_W-1:0] data_out_nxt;
    logic              par_acc, par_acc_nxt;
    logic              par_flag, par_flag_nxt;
    logic              stp_flag, stp_flag_nxt;
    logic              sh_par_en, sh_par_en_nxt;
    logic              sh_par_typ, sh_par_typ_nxt;
    logic              sh_two_stop, sh_two_stop_nxt;
    logic              data_vld_nxt, strt_glitch_nxt, par_err_nxt, stp_err_nxt, busy_nxt;
    logic              stp_hit;

    // Stop error seen so far, including the bit being sampled now.
    assign stp_hit = stp_flag | ~sampled_bit;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            par_flag    <= 1'b0;
            stp_flag    <= 1'b0;
            sh_par_en   <= 1'b0;
            sh_par_typ  <= 1'b0;
            sh_two_stop <= 1'b0;
            data_out    <= '0;
            data_vld    <= 1'b0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shreg       <= shreg_nxt;
            par_acc     <= par_acc_nxt;
            par_flag    <= par_flag_nxt;
            stp_flag    <= stp_flag_nxt;
            sh_par_en   <= sh_par_en_nxt;
            sh_par_typ  <= sh_par_typ_nxt;
            sh_two_stop <= sh_two_stop_nxt;
            data_out    <= data_out_nxt;
            data_vld    <= data_vld_nxt;
            strt_glitch <= strt_glitch_nxt;
            par_err     <= par_err_nxt;
            stp_err     <= stp_err_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        shreg_nxt       = shreg;
        par_acc_nxt     = par_acc;
        par_flag_nxt    = par_flag;
        stp_flag_nxt    = stp_flag;
        sh_par_en_nxt   = sh_par_en;
        sh_par_typ_nxt  = sh_par_typ;
        sh_two_stop_nxt = sh_two_stop;
        data_out_nxt    = data_out;
        data_vld_nxt    = 1'b0;
        strt_glitch_nxt = 1'b0;
        par_err_nxt     = 1'b0;
        stp_err_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    sh_par_en_nxt   = par_en;
                    sh_par_typ_nxt  = par_typ;
                    sh_two_stop_nxt = two_stop;
                    par_flag_nxt    = 1'b0;
                    stp_flag_nxt    = 1'b0;
                    state_nxt       = ST_START;
                end
            end
            ST_START: begin
                if (bit_vld) begin
                    if (sampled_bit) begin
                        strt_glitch_nxt = 1'b1;
                        state_nxt       = ST_IDLE;
                    end else begin
                        bit_cnt_nxt = '0;
                        par_acc_nxt = 1'b0;
                        state_nxt   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bit_vld) begin
                    shreg_nxt   = {sampled_bit, shreg[DATA_W-1:1]};
                    par_acc_nxt = par_acc ^ sampled_bit;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = sh_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_nxt = CNT_W'(bit_cnt + 1'b1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_vld) begin
                    par_flag_nxt = sampled_bit != (par_acc ^ sh_par_typ);
                    state_nxt    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_vld) begin
                    stp_flag_nxt = stp_hit;
                    // bit_cnt counts stop bits already taken: last one is at index two_stop.
                    if (bit_cnt == CNT_W'(sh_two_stop)) begin
                        par_err_nxt = par_flag;
                        stp_err_nxt = stp_hit;
                        if (!par_flag && !stp_hit) begin
                            data_vld_nxt = 1'b1;
                            data_out_nxt = shreg;
                        end
                        bit_cnt_nxt = '0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        bit_cnt_nxt = CNT_W'(bit_cnt + 1'b1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = state_nxt != ST_IDLE;
    end

`ifdef UART_FRAME_ERR_CNT_EN
    // Saturating error counters, advanced in the same edge that raises each pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_strt <= '0;
            err_cnt_par  <= '0;
            err_cnt_stp  <= '0;
        end else begin
            if (strt_glitch_nxt && (err_cnt_strt != '1))
                err_cnt_strt <= err_cnt_strt + ERR_CNT_W'(1);
            if (par_err_nxt && (err_cnt_par != '1))
                err_cnt_par <= err_cnt_par + ERR_CNT_W'(1);
            if (stp_err_nxt && (err_cnt_stp != '1))
                err_cnt_stp <= err_cnt_stp + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/uart_frame_chk.md
Name: uart_frame_chk

Overview:
Parametrised successor to the UART RX start-bit checker. It validates a complete serial frame: start bit, DATA_W data bits (LSB first), optional even/odd parity bit, and one or two stop bits. It consumes one oversampled bit per strobe from the RX data sampler. It emits the assembled byte plus per-frame start-glitch, parity-error and stop-error pulses to the RX FSM / SYS_CTRL side.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9
ERR_CNT_W, 8, width of each saturating error counter (optional feature only)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
frame_start  input  1  1-cycle pulse from the edge detector; starts a frame when idle
bit_vld  input  1  1-cycle strobe; sampled_bit is valid this cycle
sampled_bit  input  1  majority-voted bit from the data sampler
par_en  input  1  1 = frame carries a parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
two_stop  input  1  1 = two stop bits expected
data_out  output  DATA_W  last frame's data; updated only with data_vld
data_vld  output  1  1-cycle pulse: frame good, data_out updated
strt_glitch  output  1  1-cycle pulse: start bit sampled high
par_err  output  1  1-cycle pulse: parity mismatch
stp_err  output  1  1-cycle pulse: a stop bit sampled low
busy  output  1  high from the cycle after accepted frame_start until return to IDLE
err_cnt_strt, err_cnt_par, err_cnt_stp  output  ERR_CNT_W each  saturating error counts (only with UART_FRAME_ERR_CNT_EN)

Behaviour:
- Reset values: data_out=0; data_vld, strt_glitch, par_err, stp_err, busy=0; FSM=IDLE; bit counter=0; parity accumulator=0; error counters=0.
- All outputs are registered. Pulses assert in the cycle after the concluding bit_vld and last exactly 1 cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on frame_start, latch par_en/par_typ/two_stop into shadow registers and go to START. Config inputs are ignored for the rest of the frame. bit_vld in IDLE is ignored.
- START: on bit_vld:
  - sampled_bit=1 -> pulse strt_glitch, go to IDLE.
  - sampled_bit=0 -> clear counter and parity accumulator, go to DATA.
- DATA: on each bit_vld:
  - shift sampled_bit into the MSB of the shift register (LSB-first reception).
  - XOR the bit into the parity accumulator; increment the counter.
  - after the DATA_W-th bit, go to PARITY if shadow par_en, else STOP. Clear the counter.
- PARITY: on bit_vld, expected bit = accumulator XOR shadow par_typ. Store mismatch in a frame-error flag; go to STOP.
- STOP: on each bit_vld, a sampled_bit of 0 sets the stop-error flag. Stop bits required = 1 + shadow two_stop. After the last stop bit:
  - pulse par_err if the parity flag is set.
  - pulse stp_err if the stop flag is set.
  - if neither flag is set, load data_out from the shift register and pulse data_vld.
  - go to IDLE.
- Both par_err and stp_err may pulse in the same cycle. data_out holds its old value when a frame is bad.
- frame_start outside IDLE is ignored. It never restarts a frame in progress.
- frame_start and the final stop bit_vld in the same cycle: the frame concludes and the frame_start is dropped.
- bit_vld while IDLE is ignored.
- busy is high in START, DATA, PARITY and STOP.
- Reset asserted mid-frame: immediate return to reset values. No pulses are emitted for the aborted frame.

Optional Feature:
Macro UART_FRAME_ERR_CNT_EN.
- Defined: three ERR_CNT_W counters increment on strt_glitch, par_err and stp_err pulses respectively. They saturate at all-ones and clear only on reset. Ports err_cnt_strt/par/stp exist.
- Undefined: the counters and their ports are absent. All other behaviour is identical.

Test Plan:
- DATA_W=8, par_en=0, two_stop=0; frame_start, then bits 0, 0xA5 LSB-first, 1 -> data_vld pulse, data_out=0xA5, no error pulses, busy low the next cycle.
- par_en=1, par_typ=0; data 0xA5 (four ones) with parity bit 0, stop 1 -> data_vld, data_out=0xA5.
  - Same frame with parity bit 1 -> par_err pulse only, no data_vld, data_out unchanged.
- Start bit sampled 1 -> strt_glitch 1-cycle pulse, FSM back in IDLE. Following bit_vld strobes are ignored; a new frame_start then decodes 0x3C correctly.
- two_stop=1, par_en=1, par_typ=1; data 0x01, parity 0, stops 1,0 -> stp_err pulse only. Then change par_typ mid-frame on the next frame -> the latched value is used.
- Reset asserted during the DATA state after 4 bits -> all outputs 0 immediately. The next full frame of 0x7E decodes cleanly.
- With UART_FRAME_ERR_CNT_EN and ERR_CNT_W=2, send 5 start glitches -> err_cnt_strt reads 3 (saturated); err_cnt_par and err_cnt_stp read 0.
